sw_pe_affine_cfg: RTL and testbench
===================================

Name: sw_pe_affine_cfg

Overview:
Next-generation Smith-Waterman systolic-array processing element (PE) with an affine gap penalty.
- Scoring constants are loaded at run time, not fixed as parameters.
- All score arithmetic saturates.
- A stall input (`en`) freezes the whole PE.
- Each PE tracks its own best score and the reference position where that score occurred, for local-alignment traceback start.
- One instance per query symbol. PEs chain through `V`/`F`/`T`/`S`/`store_S`/`init` shift paths.

Parameters:
- WIDTH, 10, signed score width for V/E/F and the scoring constants.
- SYM_WIDTH, 2, symbol width for query and reference symbols (2 = DNA).
- POS_WIDTH, 16, width of the reference-position counter and of max_pos.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  advance enable; 0 = stall, all state held
- V_in  in  WIDTH  score from previous PE
- F_in  in  WIDTH  up-gap score from previous PE
- T_in  in  SYM_WIDTH  reference symbol shift in
- S_in  in  SYM_WIDTH  query symbol shift in
- store_S_in  in  1  latch S_in as this PE's query symbol
- init_in  in  1  computation-active shift in
- init_V, init_E, init_V_diag  in  WIDTH each  load values used while init_in=0
- cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_extend  in  WIDTH each  signed scoring constants; held stable during a run
- max_clr  in  1  clear max tracker and position counter
- V_out, E_out, F_out  out  WIDTH  registered V, E, F
- T_out, S_out  out  SYM_WIDTH  registered T, S
- store_S_out, init_out  out  1  registered store_S, init
- max_score  out  WIDTH  best V computed since clear
- max_pos  out  POS_WIDTH  position counter value when max_score was captured

Behaviour:
- Reset: every register and output is 0, including max_score, max_pos and the position counter pos.
- rst has priority over en and max_clr.
- Stall: when en=0 every register holds, including shift registers, pos and the max tracker. max_clr is ignored while en=0.
- Saturating add: sat(a+b) is computed at WIDTH+1 bits, then clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. All comparisons are signed.
- Combinational next state:
  - new_E = max(sat(V+cfg_gap_open), sat(E+cfg_gap_extend))
  - new_F = max(sat(V_in+cfg_gap_open), sat(F_in+cfg_gap_extend))
  - diag = sat(V_diag + (S==T_in ? cfg_match : cfg_mismatch))
  - new_V = max(0, new_E, new_F, diag)
- When en=1 (and rst=0):
  - store_S <= store_S_in; init <= init_in; T <= T_in; S <= S_in when store_S_in=1.
  - init_in=1: V_diag <= V_in; E <= new_E; F <= new_F; V <= new_V.
  - init_in=0: V_diag <= init_V_diag; E <= init_E; V <= init_V; F <= 0.
- Latency: one clock per shift stage. V/E/F reflect inputs of the previous enabled cycle.
- Max tracker, updated when en=1 and init_in=1:
  - If new_V > max_score (strict), then max_score <= new_V and max_pos <= pos.
  - Ties keep the earlier position.
  - pos increments after each such cycle and wraps modulo 2^POS_WIDTH with no flag.
- max_clr=1 with en=1 sets max_score and pos to 0 and max_pos to 0.
  - Same-cycle init_in=1 is still computed into V/E/F.
  - max tracker and pos end that cycle cleared; that cycle's new_V is not captured.
- S register is unaffected by init; it can be loaded while computing.

Test Plan:
- Single match: WIDTH=10, cfg 2/-2/-2/-1, store S=1, then init_in=1, T_in=1, V_in=0, F_in=0, init values 0 -> next cycle V_out=2, E_out=-1, F_out=-1, max_score=2, max_pos=0.
- Mismatch clamp: same setup with T_in=2 -> V_out=0, max_score stays 0; pos=1 on the following cycle.
- Stall: during an active run drive en=0 for 3 cycles with changing V_in/T_in -> all outputs, max_score, max_pos and pos are unchanged; the run resumes identically after en returns to 1.
- Saturation: WIDTH=6, V_in=31 active, then a match with cfg_match=2 -> V_out=31 (not -31); cfg_gap_open=-32 with V=-32 -> E term clamps to -32.
- Max tie/order: active V sequence 3,5,5,4 -> max_score=5, max_pos=1; then max_clr with en=1 -> max_score=0, max_pos=0, pos=0.
- Reset mid-run: assert rst with en=0 and init_in=1 -> all outputs 0 on the next edge; the first post-reset active cycle reproduces the single-match result.

Source files
------------

// File: rtl/sw_pe_affine_cfg.sv
// Smith-Waterman systolic processing element with affine gap penalty.
// Scoring constants come in at run time, all score arithmetic saturates,
// en=0 freezes the whole PE, and the PE remembers its best V together with
// the reference position at which that V was produced.
module sw_pe_affine_cfg #(
  parameter int WIDTH     = 10,
  parameter int SYM_WIDTH = 2,
  parameter int POS_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     V_in,
  input  logic signed [WIDTH-1:0]     F_in,
  input  logic        [SYM_WIDTH-1:0] T_in,
  input  logic        [SYM_WIDTH-1:0] S_in,
  input  logic                        store_S_in,
  input  logic                        init_in,
  input  logic signed [WIDTH-1:0]     init_V,
  input  logic signed [WIDTH-1:0]     init_E,
  input  logic signed [WIDTH-1:0]     init_V_diag,
  input  logic signed [WIDTH-1:0]     cfg_match,
  input  logic signed [WIDTH-1:0]     cfg_mismatch,
  input  logic signed [WIDTH-1:0]     cfg_gap_open,
  input  logic signed [WIDTH-1:0]     cfg_gap_extend,
  input  logic                        max_clr,
  output logic signed [WIDTH-1:0]     V_out,
  output logic signed [WIDTH-1:0]     E_out,
  output logic signed [WIDTH-1:0]     F_out,
  output logic        [SYM_WIDTH-1:0] T_out,
  output logic        [SYM_WIDTH-1:0] S_out,
  output logic                        store_S_out,
  output logic                        init_out,
  output logic signed [WIDTH-1:0]     max_score,
  output logic        [POS_WIDTH-1:0] max_pos
);

  localparam logic signed [WIDTH-1:0] SCORE_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SCORE_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SCORE_ZERO = '0;

  logic signed [WIDTH-1:0] v_diag;
  logic [POS_WIDTH-1:0]    pos;
  logic signed [WIDTH-1:0] new_e, new_f, diag, new_v;

  // One extra bit of headroom; the top two bits disagree only on overflow,
  // and the top bit then tells which rail to clamp to.
  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      sat_add = s[WIDTH] ? SCORE_MIN : SCORE_MAX;
    else
      sat_add = s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    smax = (a > b) ? a : b;
  endfunction

  // Cell recurrence: left gap (E), up gap (F), diagonal, floored at zero.
  always_comb begin
    new_e = smax(sat_add(V_out, cfg_gap_open), sat_add(E_out, cfg_gap_extend));
    new_f = smax(sat_add(V_in, cfg_gap_open), sat_add(F_in, cfg_gap_extend));
    diag  = sat_add(v_diag, (S_out == T_in) ? cfg_match : cfg_mismatch);
    new_v = smax(smax(SCORE_ZERO, new_e), smax(new_f, diag));
  end

  // Shift paths and score registers; init_in=0 preloads the boundary values.
  always_ff @(posedge clk) begin
    if (rst) begin
      V_out       <= '0;
      E_out       <= '0;
      F_out       <= '0;
      v_diag      <= '0;
      T_out       <= '0;
      S_out       <= '0;
      store_S_out <= 1'b0;
      init_out    <= 1'b0;
    end else if (en) begin
      store_S_out <= store_S_in;
      init_out    <= init_in;
      T_out       <= T_in;
      if (store_S_in) S_out <= S_in;
      if (init_in) begin
        v_diag <= V_in;
        E_out  <= new_e;
        F_out  <= new_f;
        V_out  <= new_v;
      end else begin
        v_diag <= init_V_diag;
        E_out  <= init_E;
        V_out  <= init_V;
        F_out  <= '0;
      end
    end
  end

  // Best-score tracker; strict compare keeps the earliest position on ties,
  // and a clear wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_score <= '0;
      max_pos   <= '0;
      pos       <= '0;
    end else if (en) begin
      if (max_clr) begin
        max_score <= '0;
        max_pos   <= '0;
        pos       <= '0;
      end else if (init_in) begin
        if (new_v > max_score) begin
          max_score <= new_v;
          max_pos   <= pos;
        end
        pos <= pos + POS_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_affine_cfg.sv
// Directed bench for sw_pe_affine_cfg: a WIDTH=10 instance for the main
// scoring, stall, max-tracker and reset scenarios, and a WIDTH=6 instance
// for the saturation corners.
module tb_sw_pe_affine_cfg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // WIDTH=10 instance
  logic              en, store_S_in, init_in, max_clr;
  logic signed [9:0] V_in, F_in, init_V, init_E, init_V_diag;
  logic signed [9:0] cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_extend;
  logic [1:0]        T_in, S_in, T_out, S_out;
  logic signed [9:0] V_out, E_out, F_out, max_score;
  logic [15:0]       max_pos;
  logic              store_S_out, init_out;

  sw_pe_affine_cfg #(.WIDTH(10), .SYM_WIDTH(2), .POS_WIDTH(16)) u_pe (
    .clk(clk), .rst(rst), .en(en), .V_in(V_in), .F_in(F_in), .T_in(T_in), .S_in(S_in),
    .store_S_in(store_S_in), .init_in(init_in), .init_V(init_V), .init_E(init_E),
    .init_V_diag(init_V_diag), .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
    .cfg_gap_open(cfg_gap_open), .cfg_gap_extend(cfg_gap_extend), .max_clr(max_clr),
    .V_out(V_out), .E_out(E_out), .F_out(F_out), .T_out(T_out), .S_out(S_out),
    .store_S_out(store_S_out), .init_out(init_out), .max_score(max_score), .max_pos(max_pos)
  );

  // WIDTH=6 instance
  logic              b_en, b_store_S_in, b_init_in, b_max_clr;
  logic signed [5:0] b_V_in, b_F_in, b_init_V, b_init_E, b_init_V_diag;
  logic signed [5:0] b_cfg_match, b_cfg_mismatch, b_cfg_gap_open, b_cfg_gap_extend;
  logic [1:0]        b_T_in, b_S_in, b_T_out, b_S_out;
  logic signed [5:0] b_V_out, b_E_out, b_F_out, b_max_score;
  logic [15:0]       b_max_pos;
  logic              b_store_S_out, b_init_out;

  sw_pe_affine_cfg #(.WIDTH(6), .SYM_WIDTH(2), .POS_WIDTH(16)) u_pe6 (
    .clk(clk), .rst(rst), .en(b_en), .V_in(b_V_in), .F_in(b_F_in), .T_in(b_T_in), .S_in(b_S_in),
    .store_S_in(b_store_S_in), .init_in(b_init_in), .init_V(b_init_V), .init_E(b_init_E),
    .init_V_diag(b_init_V_diag), .cfg_match(b_cfg_match), .cfg_mismatch(b_cfg_mismatch),
    .cfg_gap_open(b_cfg_gap_open), .cfg_gap_extend(b_cfg_gap_extend), .max_clr(b_max_clr),
    .V_out(b_V_out), .E_out(b_E_out), .F_out(b_F_out), .T_out(b_T_out), .S_out(b_S_out),
    .store_S_out(b_store_S_out), .init_out(b_init_out), .max_score(b_max_score), .max_pos(b_max_pos)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input int v, input int e, input int f,
                          input int ms, input int mp);
    chk({tag, ".V"}, 32'(V_out), v);
    chk({tag, ".E"}, 32'(E_out), e);
    chk({tag, ".F"}, 32'(F_out), f);
    chk({tag, ".max_score"}, 32'(max_score), ms);
    chk({tag, ".max_pos"}, 32'(max_pos), mp);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; store_S_in = 1'b0; init_in = 1'b0; max_clr = 1'b0;
    V_in = '0; F_in = '0; T_in = '0; S_in = '0;
    init_V = '0; init_E = '0; init_V_diag = '0;
    cfg_match = 10'sd2; cfg_mismatch = -10'sd2; cfg_gap_open = -10'sd2; cfg_gap_extend = -10'sd1;
    b_en = 1'b0; b_store_S_in = 1'b0; b_init_in = 1'b0; b_max_clr = 1'b0;
    b_V_in = '0; b_F_in = '0; b_T_in = '0; b_S_in = '0;
    b_init_V = '0; b_init_E = '0; b_init_V_diag = '0;
    b_cfg_match = 6'sd2; b_cfg_mismatch = -6'sd2; b_cfg_gap_open = 6'sh20; b_cfg_gap_extend = -6'sd1;

    // Reset state
    step; step;
    chk_main("reset", 0, 0, 0, 0, 0);
    chk("reset.T", 32'(T_out), 0);
    chk("reset.S", 32'(S_out), 0);
    chk("reset.init", 32'(init_out), 0);
    rst = 1'b0;

    // Load query symbol S=1 with zero boundary values
    en = 1'b1; store_S_in = 1'b1; S_in = 2'd1; init_in = 1'b0;
    step;
    chk("load.S", 32'(S_out), 1);
    chk("load.store_S", 32'(store_S_out), 1);
    store_S_in = 1'b0; S_in = 2'd3;

    // Mismatch clamps to zero, max stays 0, pos advances to 1
    init_in = 1'b1; T_in = 2'd2; V_in = '0; F_in = '0;
    step;
    chk_main("mismatch", 0, -1, -1, 0, 0);
    chk("mismatch.T", 32'(T_out), 2);
    chk("mismatch.init", 32'(init_out), 1);
    chk("mismatch.S_kept", 32'(S_out), 1);

    // Match now captures at pos=1
    T_in = 2'd1;
    step;
    chk_main("match_pos1", 2, -2, -1, 2, 1);

    // Stall with changing inputs and a max_clr that must be ignored
    en = 1'b0; max_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      V_in = 10'(100 + 7 * i); F_in = 10'(50 + i); T_in = 2'(i); init_in = i[0];
      step;
      chk_main("stall", 2, -2, -1, 2, 1);
      chk("stall.T", 32'(T_out), 1);
    end
    max_clr = 1'b0;

    // Resume: tie keeps max_pos, then a larger score lands at pos=3
    en = 1'b1; init_in = 1'b1; T_in = 2'd1; V_in = 10'sd4; F_in = '0;
    step;
    chk_main("resume1", 2, 0, 2, 2, 1);
    V_in = '0;
    step;
    chk_main("resume2", 6, 0, -1, 6, 3);

    // Max tracker clear, then V sequence 3,5,5,4 via the up-gap path
    max_clr = 1'b1; init_in = 1'b0;
    step;
    chk_main("clr", 0, 0, 0, 0, 0);
    max_clr = 1'b0; init_in = 1'b1; T_in = 2'd0; V_in = '0;
    F_in = 10'sd4; step; chk("seq3.V", 32'(V_out), 3);
    F_in = 10'sd6; step; chk("seq5a.V", 32'(V_out), 5);
    F_in = 10'sd6; step; chk("seq5b.V", 32'(V_out), 5);
    F_in = 10'sd5; step;
    chk_main("seq4", 4, 3, 4, 5, 1);

    // Clear during an active cycle: V still computed, tracker cleared
    max_clr = 1'b1; F_in = 10'sd10;
    step;
    chk_main("clr_active", 9, 2, 9, 0, 0);
    max_clr = 1'b0; F_in = 10'sd2;
    step;
    chk_main("after_clr", 7, 7, 1, 7, 0);

    // Reset mid-run with en=0 and init_in=1
    rst = 1'b1; en = 1'b0; init_in = 1'b1; V_in = 10'sd7; T_in = 2'd3;
    step;
    chk_main("midrst", 0, 0, 0, 0, 0);
    chk("midrst.S", 32'(S_out), 0);
    chk("midrst.T", 32'(T_out), 0);
    chk("midrst.init", 32'(init_out), 0);
    rst = 1'b0;

    // Single match reproduced after reset
    en = 1'b1; init_in = 1'b0; store_S_in = 1'b1; S_in = 2'd1; V_in = '0; F_in = '0;
    step;
    store_S_in = 1'b0; init_in = 1'b1; T_in = 2'd1;
    step;
    chk_main("single_match", 2, -1, -1, 2, 0);

    // Saturation on the 6-bit PE
    en = 1'b0;
    b_en = 1'b1; b_store_S_in = 1'b1; b_S_in = 2'd1; b_init_in = 1'b0;
    b_init_V = 6'sh20; b_init_E = 6'sh20; b_init_V_diag = '0;
    step;
    chk("sat.initV", 32'(b_V_out), -32);
    b_store_S_in = 1'b0; b_init_in = 1'b1; b_T_in = 2'd1; b_V_in = 6'sd31; b_F_in = 6'sh20;
    step;
    chk("sat.E_clamp", 32'(b_E_out), -32);
    chk("sat.F", 32'(b_F_out), -1);
    chk("sat.V1", 32'(b_V_out), 2);
    b_V_in = '0; b_F_in = '0;
    step;
    chk("sat.V_clamp", 32'(b_V_out), 31);
    chk("sat.E2", 32'(b_E_out), -30);
    chk("sat.max", 32'(b_max_score), 31);
    chk("sat.max_pos", 32'(b_max_pos), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
